// File: rtl/word_unpacker.sv
// Streams the 8-bit pixels of accepted 32-bit words, least-significant byte first,
// stopping after a programmed pixel count. All outputs are registered.
module word_unpacker #(
  parameter int WORD_WIDTH = 32,
  parameter int PIX_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [CNT_WIDTH-1:0]  NPIX,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WORD_WIDTH-1:0] Din,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [PIX_WIDTH-1:0]  Dout,
  output logic                  LAST,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int LANES = WORD_WIDTH / PIX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] REM_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FIN} state_t;

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  rem_reg, rem_next;
  logic [1:0]            lane_reg, lane_next;
  logic [WORD_WIDTH-1:0] buf_reg, buf_next;
  logic [PIX_WIDTH-1:0]  lane_pix [LANES];

  // Byte lanes of the word that will be held next cycle, so Dout can be registered.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_pix[gi] = buf_next[gi*PIX_WIDTH +: PIX_WIDTH];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    lane_next  = lane_reg;
    buf_next   = buf_reg;
    case (state_reg)
      IDLE: begin
        if (START) begin
          if (NPIX != '0) begin
            rem_next   = NPIX;
            lane_next  = '0;
            state_next = FETCH;
          end else begin
            state_next = FIN;
          end
        end
      end
      FETCH: begin
        if (IN_VALID && IN_READY) begin
          buf_next   = Din;
          lane_next  = '0;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (OUT_VALID && OUT_READY) begin
          rem_next = rem_reg - REM_ONE;
          // The final pixel ends the transfer even mid-word; leftover lanes are dropped.
          if (rem_reg == REM_ONE) begin
            state_next = FIN;
          end else if (lane_reg == 2'd3) begin
            state_next = FETCH;
          end else begin
            lane_next = lane_reg + 2'd1;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_reg   <= '0;
      lane_reg  <= '0;
      buf_reg   <= '0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      Dout      <= '0;
      LAST      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      rem_reg   <= rem_next;
      lane_reg  <= lane_next;
      buf_reg   <= buf_next;
      IN_READY  <= (state_next == FETCH);
      OUT_VALID <= (state_next == EMIT);
      Dout      <= (state_next == EMIT) ? lane_pix[lane_next] : '0;
      LAST      <= (state_next == EMIT) && (rem_next == REM_ONE);
      BUSY      <= (state_next != IDLE);
      DONE      <= (state_next == FIN);
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: directed vector table, hand-written reset sequence,
// and randomized transfers checked against a byte-extraction reference model.
module tb_word_unpacker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] NPIX;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] Din;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  Dout;
  logic        LAST;
  logic        BUSY;
  logic        DONE;

  always #5 CLK = ~CLK;

  word_unpacker #(.WORD_WIDTH(32), .PIX_WIDTH(8), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .NPIX(NPIX),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Din(Din),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Dout(Dout),
    .LAST(LAST), .BUSY(BUSY), .DONE(DONE)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] wbuf [16];
  logic [7:0]  exp_q [$];

  typedef struct {
    int          npix;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp_pix;
    int          exp_words;
    int          mode;      // 0 streaming, 1 random handshakes, 2 stall on lane 1
    bit          restart;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_transfer(input int npix, input int nwords, input int mode, input bit restart);
    int wi = 0, pi = 0, cyc = 0, last_hs = -10, stalls = 0;
    bit was_stall = 0, extra_rdy = 0, bad_valid = 0, restarted = 0, got_done = 0;
    logic [7:0] held_pix = '0;
    logic       held_last = 1'b0;
    @(negedge CLK);
    START = 1'b1; NPIX = npix[15:0]; IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", BUSY, 1'b1);
    chk("ready_after_start", IN_READY, npix != 0);
    while (cyc < 400 && !got_done) begin
      IN_VALID = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      Din = wbuf[(wi < 16) ? wi : 15];
      case (mode)
        1:       OUT_READY = 1'($urandom_range(0, 1));
        2:       OUT_READY = !(pi == 1 && stalls < 3);
        default: OUT_READY = 1'b1;
      endcase
      if (restart && !restarted && OUT_VALID && pi == 1) begin
        START = 1'b1; NPIX = 16'd2; restarted = 1;
      end else begin
        START = 1'b0;
      end
      if (IN_READY && wi >= nwords) extra_rdy = 1;
      if (was_stall) begin
        chk("stall_valid", OUT_VALID, 1'b1);
        chk("stall_dout", Dout, held_pix);
        chk("stall_last", LAST, held_last);
      end
      was_stall = 0;
      if (OUT_VALID) begin
        if (pi >= npix) begin
          bad_valid = 1;
        end else begin
          chk($sformatf("dout[%0d]", pi), Dout, exp_q[pi]);
          chk($sformatf("last[%0d]", pi), LAST, pi == npix - 1);
          if (OUT_READY) begin
            if (mode == 0) begin
              if (pi == 0) chk("first_latency", cyc, 1);
              else chk($sformatf("gap[%0d]", pi), cyc - last_hs, (pi % 4 == 0) ? 2 : 1);
            end
            last_hs = cyc;
            pi++;
          end else begin
            was_stall = 1; stalls++; held_pix = Dout; held_last = LAST;
          end
        end
      end
      if (IN_VALID && IN_READY) wi++;
      if (DONE) begin
        got_done = 1;
        if (npix == 0) chk("done_latency0", cyc, 0);
        else chk("done_latency", cyc - last_hs, 1);
      end
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0; IN_VALID = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("idle_busy", BUSY, 1'b0);
    chk("done_once", DONE, 1'b0);
    chk("pix_count", pi, npix);
    chk("words_used", wi, nwords);
    chk("extra_ready", extra_rdy, 1'b0);
    chk("extra_valid", bad_valid, 1'b0);
    if (mode == 2) chk("stall_cycles", stalls, 3);
    $display("[TB] transfer npix=%0d mode=%0d pixels=%0d words=%0d", npix, mode, pi, wi);
  endtask

  initial begin
    logic [63:0] ep;
    bit seen;
    int hs, c, np, nw;
    RST = 1'b1; START = 1'b0; NPIX = '0; IN_VALID = 1'b0; Din = '0; OUT_READY = 1'b0;
    #1;
    chk("rst_in_ready", IN_READY, 1'b0);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_dout", Dout, 8'h00);
    chk("rst_last", LAST, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    vecs[0] = '{4, 32'h44332211, 32'h0,        64'h44332211,         1, 0, 1'b0};
    vecs[1] = '{6, 32'hDDCCBBAA, 32'h00FFEE99, 64'h0000EE99DDCCBBAA, 2, 0, 1'b0};
    vecs[2] = '{4, 32'h44332211, 32'h0,        64'h44332211,         1, 2, 1'b0};
    vecs[3] = '{0, 32'h12345678, 32'h0,        64'h0,                0, 0, 1'b0};
    vecs[4] = '{4, 32'h44332211, 32'h0,        64'h44332211,         1, 0, 1'b1};
    vecs[5] = '{1, 32'hFFFFFFA5, 32'h0,        64'hA5,               1, 0, 1'b0};
    vecs[6] = '{5, 32'h04030201, 32'hEEEEEE05, 64'h0504030201,       2, 0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      wbuf[0] = vecs[i].w0;
      wbuf[1] = vecs[i].w1;
      exp_q.delete();
      ep = vecs[i].exp_pix;
      for (int j = 0; j < vecs[i].npix; j++) exp_q.push_back(ep[8*j +: 8]);
      run_transfer(vecs[i].npix, vecs[i].exp_words, vecs[i].mode, vecs[i].restart);
    end

    // Asynchronous reset in the middle of an 8-pixel transfer.
    wbuf[0] = 32'h44332211; wbuf[1] = 32'h88776655;
    @(negedge CLK);
    START = 1'b1; NPIX = 16'd8; IN_VALID = 1'b1; Din = wbuf[0]; OUT_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    hs = 0; c = 0;
    while (hs < 2 && c < 50) begin
      if (OUT_VALID && OUT_READY) hs++;
      if (hs < 2) begin
        @(negedge CLK);
        c++;
      end
    end
    chk("rst_reach_two_pixels", hs, 2);
    @(posedge CLK);
    #1;
    chk("pre_rst_valid", OUT_VALID, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_in_ready", IN_READY, 1'b0);
    chk("arst_out_valid", OUT_VALID, 1'b0);
    chk("arst_dout", Dout, 8'h00);
    chk("arst_last", LAST, 1'b0);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_done", DONE, 1'b0);
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE || BUSY) seen = 1;
    end
    chk("no_done_after_rst", seen, 1'b0);
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    run_transfer(4, 1, 0, 1'b0);

    // Randomized transfers against the byte-extraction model.
    for (int r = 0; r < 25; r++) begin
      np = $urandom_range(1, 20);
      nw = (np + 3) / 4;
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      exp_q.delete();
      for (int p = 0; p < np; p++) exp_q.push_back(8'((wbuf[p / 4] >> (8 * (p % 4))) & 32'hFF));
      run_transfer(np, nw, (r % 4 == 0) ? 0 : 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Reader-side companion to the accelerator's 32-bit falling-edge staging registers. The block accepts 32-bit words over a valid/ready handshake, samples them on the rising edge, and streams the 8-bit pixels they contain into the convolution datapath. Pixels leave least-significant byte first, and the block stops after a programmed pixel count. It sits between the word-wide memory and register path and the byte-wide window and filter units.

## Interface
Parameters:
- WORD_WIDTH, 32: input word width; must equal 4 × PIX_WIDTH.
- PIX_WIDTH, 8: pixel width.
- CNT_WIDTH, 16: width of the pixel-count input and counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- NPIX  in  CNT_WIDTH  number of pixels to emit; latched on the accepted START.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  block can accept a word this cycle.
- Din  in  WORD_WIDTH  upstream word.
- OUT_VALID  out  1  Dout holds a valid pixel.
- OUT_READY  in  1  downstream accepts the pixel this cycle.
- Dout  out  PIX_WIDTH  current pixel.
- LAST  out  1  the current pixel is the final pixel of the transfer.
- BUSY  out  1  a transfer is in progress.
- DONE  out  1  one-cycle pulse when a transfer completes.

## Operation
- The block has four states: IDLE, FETCH, EMIT and FIN. The state and all outputs are registered.
- IDLE:
  - START=1 with NPIX≠0: latch NPIX into the remaining-count register `rem`, clear `lane`, go to FETCH.
  - START=1 with NPIX=0: go to FIN.
  - START while not in IDLE is ignored.
- FETCH:
  - IN_READY=1 in this state and in no other state.
  - On IN_VALID&IN_READY: capture Din into the word buffer, set lane=0, go to EMIT.
- EMIT:
  - OUT_VALID=1.
  - Dout = buffer[lane*PIX_WIDTH +: PIX_WIDTH]. Lane 0 is Din[7:0].
  - LAST = (rem==1).
  - On OUT_VALID&OUT_READY: rem decrements.
    - If rem was 1, go to FIN. Remaining lanes of the word are discarded.
    - Else if lane==3, go to FETCH.
    - Else lane increments and the block stays in EMIT.
- FIN: DONE=1 for exactly one cycle, then the block returns to IDLE.
- BUSY = (state≠IDLE), which includes FIN.
- Arithmetic: `rem` is CNT_WIDTH bits and only decrements while nonzero, so it never wraps. `lane` is 2 bits and wraps 3→0 only on a word fetch.
- A word accepted from upstream is always used from lane 0. Partial words are not carried over between transfers.

## Timing
- Reset values: state=IDLE; IN_READY, OUT_VALID, LAST, BUSY and DONE are 0; Dout=0; rem=0; lane=0; buffer=0.
- Reset takes effect immediately (asynchronous). Reset mid-transfer aborts the transfer with no DONE pulse, and the buffered word is lost.
- START accepted at edge t: BUSY=1 and IN_READY=1 from cycle t+1.
- Word handshake at edge k: OUT_VALID=1 with lane 0 from cycle k+1.
- Each accepted pixel handshake advances to the next lane on the following cycle. With OUT_READY held at 1, a new pixel is presented every cycle.
- After the lane-3 handshake there is exactly one FETCH cycle, so sustained throughput is 4 pixels per 5 cycles.
- While OUT_READY=0, Dout, OUT_VALID and LAST hold stable.
- Final pixel handshake at edge f: DONE=1 in cycle f+1; BUSY=0 and the block is in IDLE from cycle f+2. A new START is accepted at the earliest at edge f+2.
- NPIX=0: DONE=1 in the cycle after START, and IN_READY never rises.
- Din from a falling-edge upstream register is sampled on the rising edge, which gives a half-cycle setup path; the block adds no other retiming.

## Test plan
- NPIX=4, Din=0x44332211, OUT_READY=1: Dout is 0x11, 0x22, 0x33, 0x44 on consecutive cycles. LAST is high only with 0x44. DONE pulses one cycle later. Exactly one word is consumed.
- NPIX=6, Din words 0xDDCCBBAA then 0x00FFEE99: output is AA BB CC DD, one bubble cycle, then 99 EE. LAST is high on EE. The upper two bytes of the second word are discarded, and IN_READY does not rise again.
- NPIX=4, OUT_READY low for 3 cycles while lane 1 (0x22) is presented: Dout=0x22 and OUT_VALID=1 hold for those 3 cycles. The sequence then completes unchanged.
- NPIX=0: DONE is high in the cycle after START, BUSY is high for one cycle, and IN_READY and OUT_VALID stay 0.
- NPIX=8, RST asserted asynchronously after 2 pixels: all outputs go to 0 immediately and DONE never pulses. A subsequent START with NPIX=4 and Din=0x44332211 produces 11 22 33 44 correctly.
- START pulsed again while in EMIT with NPIX=2: it is ignored. The original count completes, followed by a single DONE.
